seg7_scan_decoder: RTL and testbench
====================================

# seg7_scan_decoder

Receive-side counterpart of the hex-to-seven-segment encoder. The block samples a multiplexed display bus (one-hot digit select plus abcdefg segment lines), filters scan transitions and ghosting with a stability counter, and decodes each stable pattern back to a 4-bit hex value per digit. It sits in self-checking display testbenches and loopback designs, downstream of the display driver, and rebuilds the digit values that the driver is showing.

## Interface
- N_DIGITS, 4, number of multiplexed digits; must be ≥ 1.
- STABLE_CYCLES, 4, consecutive identical samples required before a pattern is committed; must be ≥ 2.

- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- an  in  N_DIGITS  digit select, active-high, one-hot; bit i selects digit i.
- segs  in  7  segment lines, active-high, bit 6 = a … bit 0 = g.
- digits  out  4*N_DIGITS  decoded hex value; digit i occupies bits [4i+3:4i].
- valid  out  N_DIGITS  bit i = 1 when the last committed pattern of digit i was a legal hex glyph.
- upd  out  1  one-cycle pulse; a digit register was committed on the previous edge.
- upd_idx  out  clog2(N_DIGITS) (min 1)  index of the digit committed; meaningful only while upd = 1.
- frame  out  1  one-cycle pulse; every digit has been committed at least once since the last frame pulse.

## Operation
- Input register in_r = {an, segs} is loaded every edge.
- Stability counter cnt (saturating at STABLE_CYCLES):
  - {an, segs} ≠ in_r → cnt ← 1.
  - Otherwise → cnt ← cnt + 1 (saturating).
- Commit condition: {an, segs} = in_r, cnt = STABLE_CYCLES−1, and in_r.an is exactly one-hot. A stable run therefore commits exactly once.
- An all-zero or multi-hot an never commits; the counter still runs.
- On commit to digit i:
  - digits[i] ← decoded value; valid[i] ← legal; upd ← 1; upd_idx ← i; seen[i] ← 1.
- Decode table (abcdefg), all other patterns illegal:
  - 0 = 1111110, 1 = 0110000, 2 = 1101101, 3 = 1111001, 4 = 0110011, 5 = 1011011, 6 = 1011111, 7 = 1110000
  - 8 = 1111111, 9 = 1111011, A = 1110111, b = 0011111, C = 1001110, d = 0111101, E = 1001111, F = 1000111
- Illegal pattern, including blank 0000000 → digits[i] ← 0, valid[i] ← 0.
- Frame tracking: seen is an N_DIGITS mask.
  - If a commit makes seen all-ones → frame ← 1 in the same cycle as upd, and seen ← 0 (the committing bit is not retained).
  - Re-committing a digit that is already seen only refreshes its value; seen is unchanged.
- Reset, synchronous to clk, overrides everything, including a commit in the same cycle. After the reset edge:
  - digits = 0, valid = 0, upd = 0, upd_idx = 0, frame = 0.
  - in_r = 0, cnt = 0, seen = 0.

## Timing
- Inputs change before edge 1 and are held → in_r updates at edge 1 (cnt = 1) → commit at edge STABLE_CYCLES.
- digits, valid, upd and upd_idx are visible after that edge. Latency = STABLE_CYCLES edges; with the default, 4 edges.
- A pattern held fewer than STABLE_CYCLES cycles is discarded: no upd, outputs unchanged.
- A one-cycle glitch inside a long run restarts the count. The original value recommits STABLE_CYCLES edges after the glitch ends, producing a second upd.
- upd and frame are single-cycle pulses registered on the commit edge. At most one commit occurs per cycle.
- Outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- Reset then hold: assert rst for 2 cycles while an=0001 and segs=1111001, then release. Required: all outputs 0 during reset; exactly 4 edges after release, digits[3:0]=3, valid=0001, upd=1, upd_idx=0, frame=0.
- Full scan, N_DIGITS=4: hold an=0001/0010/0100/1000 with segs of 1, 2, A and F for 6 cycles each. Required: digits=16'hFA21, valid=1111, four upd pulses, and one frame pulse coincident with the 4th upd.
- Short glitch: digit 1 stable on 5 (1011011), then a 2-cycle 8 (1111111), then 5 again. Required: no commit of 8; digits[7:4] stays 5; one extra upd when 5 recommits.
- Illegal and blank patterns: digit 2 gets segs=1000000, then 0000000, each held 5 cycles. Required: digits[11:8]=0 and valid[2]=0 after each; upd pulses with upd_idx=2.
- Bad select: an=0011, then an=0000, each with segs=1111111 held 10 cycles. Required: no upd, outputs unchanged.
- Reset mid-run: assert rst on the cycle where cnt=STABLE_CYCLES−1. Required: no upd, all outputs 0, seen cleared; the next frame needs all 4 digits again.

Source files
------------

// File: rtl/seg7_if.sv
// Multiplexed seven-segment display bus: scan inputs from the driver side and
// the decoded per-digit view rebuilt by the receiver.
interface seg7_if #(
  parameter int N_DIGITS = 4
);
  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  logic [N_DIGITS-1:0]   an;
  logic [6:0]            segs;
  logic [4*N_DIGITS-1:0] digits;
  logic [N_DIGITS-1:0]   valid;
  logic                  upd;
  logic [IDX_W-1:0]      upd_idx;
  logic                  frame;

  modport master (
    output an, segs,
    input  digits, valid, upd, upd_idx, frame
  );

  modport slave (
    input  an, segs,
    output digits, valid, upd, upd_idx, frame
  );
endinterface

// File: rtl/seg7_scan_decoder.sv
// Samples a multiplexed seven-segment bus, waits for a stable scan pattern and
// decodes it back to a hex value for the selected digit.
module seg7_scan_decoder #(
  parameter int N_DIGITS      = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic  clk,
  input  logic  rst,
  seg7_if.slave bus
);
  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam int IN_W  = N_DIGITS + 7;
  localparam logic [CNT_W-1:0]    CNT_MAX  = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0]    CNT_HIT  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [N_DIGITS-1:0] ALL_SEEN = '1;

  // Returns {legal, value}; anything outside the 16 glyphs decodes to 0 / illegal.
  function automatic logic [4:0] decode_glyph(input logic [6:0] s);
    case (s)
      7'b1111110: decode_glyph = 5'h10;
      7'b0110000: decode_glyph = 5'h11;
      7'b1101101: decode_glyph = 5'h12;
      7'b1111001: decode_glyph = 5'h13;
      7'b0110011: decode_glyph = 5'h14;
      7'b1011011: decode_glyph = 5'h15;
      7'b1011111: decode_glyph = 5'h16;
      7'b1110000: decode_glyph = 5'h17;
      7'b1111111: decode_glyph = 5'h18;
      7'b1111011: decode_glyph = 5'h19;
      7'b1110111: decode_glyph = 5'h1A;
      7'b0011111: decode_glyph = 5'h1B;
      7'b1001110: decode_glyph = 5'h1C;
      7'b0111101: decode_glyph = 5'h1D;
      7'b1001111: decode_glyph = 5'h1E;
      7'b1000111: decode_glyph = 5'h1F;
      default:    decode_glyph = 5'h00;
    endcase
  endfunction

  logic [IN_W-1:0]       w_in_p0;
  logic [IN_W-1:0]       r_in_p1;
  logic [CNT_W-1:0]      r_cnt_p1;
  logic [N_DIGITS-1:0]   w_an_p1;
  logic                  w_same;
  logic                  w_onehot;
  logic                  w_commit;
  logic [IDX_W-1:0]      w_idx;
  logic [4:0]            w_dec;
  logic [N_DIGITS-1:0]   w_seen_nxt;

  logic [4*N_DIGITS-1:0] r_digits_p2;
  logic [N_DIGITS-1:0]   r_valid_p2;
  logic                  r_upd_p2;
  logic [IDX_W-1:0]      r_upd_idx_p2;
  logic                  r_frame_p2;
  logic [N_DIGITS-1:0]   r_seen;

  // Stage p0 -> p1: raw sample compared against the registered copy
  assign w_in_p0  = {bus.an, bus.segs};
  assign w_an_p1  = r_in_p1[IN_W-1:7];
  assign w_same   = (w_in_p0 == r_in_p1);
  assign w_onehot = (w_an_p1 != '0) && ((w_an_p1 & (w_an_p1 - N_DIGITS'(1))) == '0);
  assign w_commit = w_same && (r_cnt_p1 == CNT_HIT) && w_onehot;
  assign w_dec    = decode_glyph(r_in_p1[6:0]);

  always_comb begin
    w_idx = '0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (w_an_p1[i]) w_idx = IDX_W'(i);
    end
  end

  assign w_seen_nxt = r_seen | (N_DIGITS'(1) << w_idx);

  // Stage p1 -> p2: commit into the per-digit result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_in_p1      <= '0;
      r_cnt_p1     <= '0;
      r_digits_p2  <= '0;
      r_valid_p2   <= '0;
      r_upd_p2     <= 1'b0;
      r_upd_idx_p2 <= '0;
      r_frame_p2   <= 1'b0;
      r_seen       <= '0;
    end else begin
      r_in_p1 <= w_in_p0;
      if (!w_same) begin
        r_cnt_p1 <= CNT_W'(1);
      end else if (r_cnt_p1 != CNT_MAX) begin
        r_cnt_p1 <= r_cnt_p1 + CNT_W'(1);
      end
      r_upd_p2   <= w_commit;
      r_frame_p2 <= 1'b0;
      if (w_commit) begin
        r_digits_p2[4*w_idx +: 4] <= w_dec[3:0];
        r_valid_p2[w_idx]         <= w_dec[4];
        r_upd_idx_p2              <= w_idx;
        // The frame-completing digit starts the next frame unseen
        if (w_seen_nxt == ALL_SEEN) begin
          r_frame_p2 <= 1'b1;
          r_seen     <= '0;
        end else begin
          r_seen <= w_seen_nxt;
        end
      end
    end
  end

  assign bus.digits  = r_digits_p2;
  assign bus.valid   = r_valid_p2;
  assign bus.upd     = r_upd_p2;
  assign bus.upd_idx = r_upd_idx_p2;
  assign bus.frame   = r_frame_p2;
endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed bench for seg7_scan_decoder with N_DIGITS=4, STABLE_CYCLES=4.
module tb_seg7_scan_decoder;
  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;
  int   upd_cnt;
  int   frame_cnt;
  int   frame_upd;
  logic frame_with_upd;
  logic [1:0] last_idx;

  localparam logic [6:0] GLYPH [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };

  seg7_if #(.N_DIGITS(4)) bus ();

  seg7_scan_decoder #(.N_DIGITS(4), .STABLE_CYCLES(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive a pattern for n edges, sampling 1 time unit after each edge.
  task automatic hold(input logic [3:0] a, input logic [6:0] s, input int n);
    bus.an   = a;
    bus.segs = s;
    repeat (n) begin
      @(posedge clk);
      #1;
      if (bus.upd === 1'b1) begin
        upd_cnt++;
        last_idx = bus.upd_idx;
      end
      if (bus.frame === 1'b1) begin
        frame_cnt++;
        frame_upd = upd_cnt;
        frame_with_upd = bus.upd;
      end
    end
  endtask

  task automatic clear_counts();
    upd_cnt = 0;
    frame_cnt = 0;
    frame_upd = 0;
    frame_with_upd = 1'b0;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.an = 4'b0001;
    bus.segs = 7'b1111001;
    repeat (2) begin
      @(posedge clk);
      #1;
      n_cmp++;
      if ({bus.digits, bus.valid, bus.upd, bus.upd_idx, bus.frame} !== 25'd0) begin
        n_err++;
        $display("FAIL reset_outputs: got digits=%h valid=%b upd=%b idx=%0d frame=%b required all 0",
                 bus.digits, bus.valid, bus.upd, bus.upd_idx, bus.frame);
      end
    end
    rst = 1'b0;
    clear_counts();
    hold(4'b0001, 7'b1111001, 3);
    n_cmp++;
    if (upd_cnt !== 0) begin
      n_err++;
      $display("FAIL reset_early_upd: got %0d upd pulses required 0", upd_cnt);
    end
    hold(4'b0001, 7'b1111001, 1);
    n_cmp++;
    if (bus.upd !== 1'b1 || bus.digits !== 16'h0003 || bus.valid !== 4'b0001 ||
        bus.upd_idx !== 2'd0 || bus.frame !== 1'b0) begin
      n_err++;
      $display("FAIL reset_first_commit: got upd=%b digits=%h valid=%b idx=%0d frame=%b required 1 0003 0001 0 0",
               bus.upd, bus.digits, bus.valid, bus.upd_idx, bus.frame);
    end
    hold(4'b0001, 7'b1111001, 3);
    n_cmp++;
    if (upd_cnt !== 1) begin
      n_err++;
      $display("FAIL reset_single_commit: got %0d upd pulses required 1", upd_cnt);
    end
  endtask

  task automatic test_decode_table();
    logic [15:0] d;
    clear_counts();
    for (int k = 0; k < 16; k++) begin
      hold(4'b0001, GLYPH[k], 5);
      d = bus.digits;
      n_cmp++;
      if (d[3:0] !== 4'(k) || bus.valid !== 4'b0001) begin
        n_err++;
        $display("FAIL decode_%0d: got value=%h valid=%b required %h 0001", k, d[3:0], bus.valid, 4'(k));
      end
    end
    d = bus.digits;
    n_cmp++;
    if (upd_cnt !== 16 || d[15:4] !== 12'h000 || frame_cnt !== 0) begin
      n_err++;
      $display("FAIL decode_totals: got upd=%0d upper=%h frames=%0d required 16 000 0",
               upd_cnt, d[15:4], frame_cnt);
    end
  endtask

  task automatic test_full_scan();
    pulse_reset();
    clear_counts();
    hold(4'b0001, 7'b0110000, 6);
    hold(4'b0010, 7'b1101101, 6);
    hold(4'b0100, 7'b1110111, 6);
    n_cmp++;
    if (frame_cnt !== 0) begin
      n_err++;
      $display("FAIL scan_early_frame: got %0d frames required 0", frame_cnt);
    end
    hold(4'b1000, 7'b1000111, 6);
    n_cmp++;
    if (bus.digits !== 16'hFA21 || bus.valid !== 4'b1111) begin
      n_err++;
      $display("FAIL scan_values: got digits=%h valid=%b required FA21 1111", bus.digits, bus.valid);
    end
    n_cmp++;
    if (upd_cnt !== 4 || last_idx !== 2'd3) begin
      n_err++;
      $display("FAIL scan_upd: got %0d pulses last_idx=%0d required 4 3", upd_cnt, last_idx);
    end
    n_cmp++;
    if (frame_cnt !== 1 || frame_upd !== 4 || frame_with_upd !== 1'b1) begin
      n_err++;
      $display("FAIL scan_frame: got frames=%0d at_upd=%0d with_upd=%b required 1 4 1",
               frame_cnt, frame_upd, frame_with_upd);
    end
  endtask

  task automatic test_glitch();
    hold(4'b0010, 7'b1011011, 6);
    clear_counts();
    hold(4'b0010, 7'b1111111, 2);
    n_cmp++;
    if (upd_cnt !== 0 || bus.digits !== 16'hFA51) begin
      n_err++;
      $display("FAIL glitch_discard: got upd=%0d digits=%h required 0 FA51", upd_cnt, bus.digits);
    end
    hold(4'b0010, 7'b1011011, 3);
    n_cmp++;
    if (upd_cnt !== 0) begin
      n_err++;
      $display("FAIL glitch_early_recommit: got %0d pulses required 0", upd_cnt);
    end
    hold(4'b0010, 7'b1011011, 1);
    n_cmp++;
    if (bus.upd !== 1'b1 || bus.upd_idx !== 2'd1 || bus.digits !== 16'hFA51) begin
      n_err++;
      $display("FAIL glitch_recommit: got upd=%b idx=%0d digits=%h required 1 1 FA51",
               bus.upd, bus.upd_idx, bus.digits);
    end
  endtask

  task automatic test_illegal();
    clear_counts();
    hold(4'b0100, 7'b1000000, 5);
    n_cmp++;
    if (upd_cnt !== 1 || last_idx !== 2'd2 || bus.digits !== 16'hF051 || bus.valid !== 4'b1011) begin
      n_err++;
      $display("FAIL illegal_segs: got upd=%0d idx=%0d digits=%h valid=%b required 1 2 F051 1011",
               upd_cnt, last_idx, bus.digits, bus.valid);
    end
    hold(4'b0100, 7'b0000000, 5);
    n_cmp++;
    if (upd_cnt !== 2 || last_idx !== 2'd2 || bus.digits !== 16'hF051 || bus.valid !== 4'b1011) begin
      n_err++;
      $display("FAIL blank_segs: got upd=%0d idx=%0d digits=%h valid=%b required 2 2 F051 1011",
               upd_cnt, last_idx, bus.digits, bus.valid);
    end
  endtask

  task automatic test_bad_select();
    clear_counts();
    hold(4'b0011, 7'b1111111, 10);
    hold(4'b0000, 7'b1111111, 10);
    n_cmp++;
    if (upd_cnt !== 0 || frame_cnt !== 0 || bus.digits !== 16'hF051 || bus.valid !== 4'b1011) begin
      n_err++;
      $display("FAIL bad_select: got upd=%0d frames=%0d digits=%h valid=%b required 0 0 F051 1011",
               upd_cnt, frame_cnt, bus.digits, bus.valid);
    end
  endtask

  task automatic test_reset_mid_run();
    clear_counts();
    hold(4'b0001, 7'b1111110, 3);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    n_cmp++;
    if ({bus.digits, bus.valid, bus.upd, bus.upd_idx, bus.frame} !== 25'd0 || upd_cnt !== 0) begin
      n_err++;
      $display("FAIL reset_mid_run: got digits=%h valid=%b upd=%b frame=%b required all 0",
               bus.digits, bus.valid, bus.upd, bus.frame);
    end
    hold(4'b0001, 7'b1111110, 6);
    hold(4'b1000, 7'b1110000, 6);
    n_cmp++;
    if (frame_cnt !== 0 || upd_cnt !== 2) begin
      n_err++;
      $display("FAIL seen_cleared: got frames=%0d upd=%0d required 0 2", frame_cnt, upd_cnt);
    end
    hold(4'b0010, 7'b0011111, 6);
    hold(4'b0100, 7'b0111101, 6);
    n_cmp++;
    if (frame_cnt !== 1 || frame_upd !== 4 || bus.digits !== 16'h7DB0 || bus.valid !== 4'b1111) begin
      n_err++;
      $display("FAIL refill_frame: got frames=%0d at_upd=%0d digits=%h valid=%b required 1 4 7DB0 1111",
               frame_cnt, frame_upd, bus.digits, bus.valid);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    last_idx = 2'd0;
    clear_counts();
    test_reset();
    test_decode_table();
    test_full_scan();
    test_glitch();
    test_illegal();
    test_bad_select();
    test_reset_mid_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
